fetch_stage: RTL and testbench

Instruction-fetch stage: owns the fetch PC, drives the instruction-memory request/response handshake, and loads the IF/ID pipeline register consumed by decode and the data hazard detector. It obeys PCWrite/IF_IDWrite from the hazard detector and redirects on taken branches resolved in ID. A one-entry hold buffer absorbs a fetched instruction that cannot enter IF/ID because decode is stalled.

---
 rtl/fetch_stage_pkg.sv | 39 +++
 rtl/if_id_reg.sv | 42 ++++
 rtl/fetch_stage.sv | 180 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage and its neighbours.
// Holds the NOP encoding, the fetch FSM state encoding, the default reset
// PC, the opcode constants shared with the hazard detector, and a small
// saturating-increment helper.
package fetch_stage_pkg;

    // Encoding of an empty slot in the IF/ID register
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    // Fetch address used after reset unless the top is overridden
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Opcode field values shared with the hazard detector
    localparam logic [5:0]  OP_RTYPE         = 6'h00;
    localparam logic [5:0]  OP_J             = 6'h02;
    localparam logic [5:0]  OP_BEQ           = 6'h04;
    localparam logic [5:0]  OP_BNE           = 6'h05;
    localparam logic [5:0]  OP_LW            = 6'h23;
    localparam logic [5:0]  OP_SW            = 6'h2B;

    // Fetch FSM states
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_HOLD = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage : fetch_stage_pkg

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: {instruction, PC+4, valid}, 65 bits in total.
// Ports:
//   clk, reset     - clock and synchronous active-high reset (clears all bits)
//   we             - load {instr_d, pc_plus4_d, 1}
//   bubble         - load a bubble: instruction NOP, PC+4 kept, valid 0
//                    (takes priority over we)
//   instr_d, pc_plus4_d - data to load
//   instr_q, pc_plus4_q, valid_q - register contents
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic        bubble,
    input  logic [31:0] instr_d,
    input  logic [31:0] pc_plus4_d,
    output logic [31:0] instr_q,
    output logic [31:0] pc_plus4_q,
    output logic        valid_q
);

    logic [64:0] data_r;

    // Pipeline register storage; a bubble keeps the previous PC+4 field
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r <= 65'd0;
        end else if (bubble) begin
            data_r <= {NOP_INSTR, data_r[32:1], 1'b0};
        end else if (we) begin
            data_r <= {instr_d, pc_plus4_d, 1'b1};
        end else begin
            data_r <= data_r;
        end
    end

    assign instr_q    = data_r[64:33];
    assign pc_plus4_q = data_r[32:1];
    assign valid_q    = data_r[0];

endmodule : if_id_reg

// File: rtl/fetch_stage.sv
// Instruction-fetch stage. Owns the fetch PC, runs the instruction-memory
// request/response handshake and loads the IF/ID register. Obeys PCWrite /
// IF_IDWrite from the hazard detector and redirects on taken branches
// resolved in ID. A one-entry hold buffer keeps a returned instruction that
// cannot enter IF/ID because decode is stalled.
// Ports:
//   Clk, Reset                 - clock, synchronous active-high reset
//   PCWrite, IF_IDWrite        - hazard detector enables
//   BranchTaken, BranchTarget  - redirect from ID (target bits [1:0] ignored)
//   IMemReq, IMemAddr          - fetch request and address (registered)
//   IMemReady, IMemData        - response strobe and instruction word
//   IF_IDInstruction, IF_IDPCPlus4, IF_IDValid - IF/ID register contents
//   PC                         - current fetch PC
//   BubbleCount                - saturating count of memory-wait bubbles
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PCWrite,
    input  logic        IF_IDWrite,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic [31:0] IMemData,
    output logic [31:0] IF_IDInstruction,
    output logic [31:0] IF_IDPCPlus4,
    output logic        IF_IDValid,
    output logic [31:0] PC,
    output logic [15:0] BubbleCount
);

    fetch_state_e state_r, state_nxt_s;
    logic [31:0]  pc_r, pc_nxt_s;
    logic [31:0]  pending_pc_r, pending_pc_nxt_s;
    logic [31:0]  hold_buf_r, hold_buf_nxt_s;
    logic [15:0]  bubble_cnt_r;
    logic         bubble_inc_s;
    logic         req_r;

    logic         advance_s;
    logic         redirect_s;
    logic [31:0]  target_s;
    logic [31:0]  pc_plus4_s;

    logic         ifid_we_s;
    logic         ifid_bubble_s;
    logic [31:0]  ifid_instr_s;

    assign advance_s  = PCWrite & IF_IDWrite;
    // A branch stalled in ID re-asserts later, so it only counts when IF/ID moves
    assign redirect_s = BranchTaken & IF_IDWrite;
    assign target_s   = {BranchTarget[31:2], 2'b00};
    assign pc_plus4_s = pc_r + 32'd4;

    // Next-state, PC, buffer and IF/ID load decisions
    always_comb begin
        state_nxt_s      = state_r;
        pc_nxt_s         = pc_r;
        pending_pc_nxt_s = pending_pc_r;
        hold_buf_nxt_s   = hold_buf_r;
        bubble_inc_s     = 1'b0;
        ifid_we_s        = 1'b0;
        ifid_bubble_s    = 1'b0;
        ifid_instr_s     = IMemData;

        case (state_r)
            ST_REQ: begin
                if (redirect_s) begin
                    ifid_bubble_s    = 1'b1;
                    pending_pc_nxt_s = target_s;
                    if (IMemReady) begin
                        // Response for the old PC arrives now: drop it and retarget
                        pc_nxt_s    = target_s;
                        state_nxt_s = ST_REQ;
                    end else begin
                        state_nxt_s = ST_DROP;
                    end
                end else if (IMemReady && advance_s) begin
                    ifid_we_s = 1'b1;
                    pc_nxt_s  = pc_plus4_s;
                end else if (IMemReady) begin
                    hold_buf_nxt_s = IMemData;
                    state_nxt_s    = ST_HOLD;
                end else if (IF_IDWrite) begin
                    ifid_bubble_s = 1'b1;
                    bubble_inc_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (redirect_s) begin
                    ifid_bubble_s = 1'b1;
                    pc_nxt_s      = target_s;
                    state_nxt_s   = ST_REQ;
                end else if (advance_s) begin
                    ifid_we_s    = 1'b1;
                    ifid_instr_s = hold_buf_r;
                    pc_nxt_s     = pc_plus4_s;
                    state_nxt_s  = ST_REQ;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_DROP: begin
                if (redirect_s) begin
                    pending_pc_nxt_s = target_s;
                end else begin
                    pending_pc_nxt_s = pending_pc_r;
                end
                if (IMemReady) begin
                    // A same-cycle redirect is newer than the latched target
                    pc_nxt_s    = redirect_s ? target_s : pending_pc_r;
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_DROP;
                end
                if (IF_IDWrite) begin
                    ifid_bubble_s = 1'b1;
                end else begin
                    ifid_bubble_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_REQ;
            end
        endcase
    end

    // FSM, PC, pending target, hold buffer and request register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r      <= ST_REQ;
            pc_r         <= RESET_PC;
            pending_pc_r <= RESET_PC;
            hold_buf_r   <= NOP_INSTR;
            req_r        <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            pending_pc_r <= pending_pc_nxt_s;
            hold_buf_r   <= hold_buf_nxt_s;
            req_r        <= (state_nxt_s != ST_HOLD);
        end
    end

    // Memory-wait bubble counter, sticks at its maximum
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bubble_cnt_r <= 16'd0;
        end else if (bubble_inc_s) begin
            bubble_cnt_r <= sat_inc16(bubble_cnt_r);
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (Clk),
        .reset      (Reset),
        .we         (ifid_we_s),
        .bubble     (ifid_bubble_s),
        .instr_d    (ifid_instr_s),
        .pc_plus4_d (pc_plus4_s),
        .instr_q    (IF_IDInstruction),
        .pc_plus4_q (IF_IDPCPlus4),
        .valid_q    (IF_IDValid)
    );

    assign IMemReq     = req_r;
    assign IMemAddr    = pc_r;
    assign PC          = pc_r;
    assign BubbleCount = bubble_cnt_r;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a table of per-cycle input/expected rows
// followed by a hand-written zero-wait streaming sequence.
module tb_fetch_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        PCWrite;
    logic        IF_IDWrite;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemReady;
    logic [31:0] IMemData;
    logic [31:0] IF_IDInstruction;
    logic [31:0] IF_IDPCPlus4;
    logic        IF_IDValid;
    logic [31:0] PC;
    logic [15:0] BubbleCount;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .PCWrite          (PCWrite),
        .IF_IDWrite       (IF_IDWrite),
        .BranchTaken      (BranchTaken),
        .BranchTarget     (BranchTarget),
        .IMemReq          (IMemReq),
        .IMemAddr         (IMemAddr),
        .IMemReady        (IMemReady),
        .IMemData         (IMemData),
        .IF_IDInstruction (IF_IDInstruction),
        .IF_IDPCPlus4     (IF_IDPCPlus4),
        .IF_IDValid       (IF_IDValid),
        .PC               (PC),
        .BubbleCount      (BubbleCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst;
        logic        pcw;
        logic        ifw;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;
        logic [31:0] dat;
        logic        e_req;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic [15:0] e_bub;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic pcw, input logic ifw,
                       input logic br, input logic [31:0] tgt,
                       input logic rdy, input logic [31:0] dat,
                       input logic e_req, input logic [31:0] e_pc,
                       input logic [31:0] e_instr, input logic [31:0] e_pc4,
                       input logic e_valid, input logic [15:0] e_bub);
        vec_t v;
        v.rst = rst; v.pcw = pcw; v.ifw = ifw; v.br = br; v.tgt = tgt;
        v.rdy = rdy; v.dat = dat; v.e_req = e_req; v.e_pc = e_pc;
        v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid; v.e_bub = e_bub;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        Reset        = v.rst;
        PCWrite      = v.pcw;
        IF_IDWrite   = v.ifw;
        BranchTaken  = v.br;
        BranchTarget = v.tgt;
        IMemReady    = v.rdy;
        IMemData     = v.dat;
    endtask

    initial begin
        logic [31:0] exp_pc;
        //   rst pcw ifw br tgt           rdy dat            | req pc            instr          pc4           v  bub
        // reset
        add(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,         1'b0,32'h0,         32'h0,         32'h0,        1'b0,16'd0);
        add(1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,         1'b0,32'h0,         32'h0,         32'h0,        1'b0,16'd0);
        // zero-wait stream
        add(1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,32'hA000_0000, 1'b1,32'h4,         32'hA000_0000, 32'h4,        1'b1,16'd0);
        add(1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,32'hA000_0004, 1'b1,32'h8,         32'hA000_0004, 32'h8,        1'b1,16'd0);
        add(1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,32'hA000_0008, 1'b1,32'hC,         32'hA000_0008, 32'hC,        1'b1,16'd0);
        add(1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,32'hA000_000C, 1'b1,32'h10,        32'hA000_000C, 32'h10,       1'b1,16'd0);
        // memory wait: three counted bubbles, address stable
        add(1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,         1'b1,32'h10,        32'h0,         32'h10,       1'b0,16'd1);
        add(1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,         1'b1,32'h10,        32'h0,         32'h10,       1'b0,16'd2);
        add(1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,         1'b1,32'h10,        32'h0,         32'h10,       1'b0,16'd3);
        add(1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,32'hA000_0010, 1'b1,32'h14,        32'hA000_0010, 32'h14,       1'b1,16'd3);
        // stall while memory responds -> HOLD, released once
        add(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,32'h8C22_0004, 1'b0,32'h14,        32'hA000_0010, 32'h14,       1'b1,16'd3);
        add(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,         1'b0,32'h14,        32'hA000_0010, 32'h14,       1'b1,16'd3);
        add(1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,         1'b1,32'h18,        32'h8C22_0004, 32'h18,       1'b1,16'd3);
        add(1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,32'hA000_0018, 1'b1,32'h1C,        32'hA000_0018, 32'h1C,       1'b1,16'd3);
        // branch while memory waits -> DROP, late response discarded
        add(1'b0,1'b1,1'b1,1'b1,32'h40,       1'b0,32'h0,         1'b1,32'h1C,        32'h0,         32'h1C,       1'b0,16'd3);
        add(1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,         1'b1,32'h1C,        32'h0,         32'h1C,       1'b0,16'd3);
        add(1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,32'hDEAD_BEEF, 1'b1,32'h40,        32'h0,         32'h1C,       1'b0,16'd3);
        add(1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,32'hA000_0040, 1'b1,32'h44,        32'hA000_0040, 32'h44,       1'b1,16'd3);
        // branch with IF_IDWrite=0 ignored (REQ, then HOLD)
        add(1'b0,1'b1,1'b0,1'b1,32'h80,       1'b0,32'h0,         1'b1,32'h44,        32'hA000_0040, 32'h44,       1'b1,16'd3);
        add(1'b0,1'b0,1'b0,1'b1,32'h80,       1'b1,32'hA000_0044, 1'b0,32'h44,        32'hA000_0040, 32'h44,       1'b1,16'd3);
        add(1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,         1'b1,32'h48,        32'hA000_0044, 32'h48,       1'b1,16'd3);
        // zero-wait taken branch, low target bits ignored
        add(1'b0,1'b1,1'b1,1'b1,32'h103,      1'b1,32'hA000_0048, 1'b1,32'h100,       32'h0,         32'h48,       1'b0,16'd3);
        add(1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,32'hA000_0100, 1'b1,32'h104,       32'hA000_0100, 32'h104,      1'b1,16'd3);
        // reset during DROP, stale response in reset cycle ignored
        add(1'b0,1'b1,1'b1,1'b1,32'h200,      1'b0,32'h0,         1'b1,32'h104,       32'h0,         32'h104,      1'b0,16'd3);
        add(1'b1,1'b1,1'b1,1'b0,32'h0,        1'b1,32'hBAD0_BAD0, 1'b0,32'h0,         32'h0,         32'h0,        1'b0,16'd0);
        add(1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,32'hA000_0000, 1'b1,32'h4,         32'hA000_0000, 32'h4,        1'b1,16'd0);
        // PC wrap at the top of the address space
        add(1'b0,1'b1,1'b1,1'b1,32'hFFFF_FFFC,1'b1,32'hA000_0004, 1'b1,32'hFFFF_FFFC, 32'h0,         32'h4,        1'b0,16'd0);
        add(1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,32'hA000_00FC, 1'b1,32'h0,         32'hA000_00FC, 32'h0,        1'b1,16'd0);
        // redirect during DROP overwrites the pending target
        add(1'b0,1'b1,1'b1,1'b1,32'h300,      1'b0,32'h0,         1'b1,32'h0,         32'h0,         32'h0,        1'b0,16'd0);
        add(1'b0,1'b1,1'b1,1'b1,32'h400,      1'b0,32'h0,         1'b1,32'h0,         32'h0,         32'h0,        1'b0,16'd0);
        add(1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,32'h1234_5678, 1'b1,32'h400,       32'h0,         32'h0,        1'b0,16'd0);
        add(1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,32'hA000_0400, 1'b1,32'h404,       32'hA000_0400, 32'h404,      1'b1,16'd0);
        // redirect on the DROP response cycle beats the pending target
        add(1'b0,1'b1,1'b1,1'b1,32'h500,      1'b0,32'h0,         1'b1,32'h404,       32'h0,         32'h404,      1'b0,16'd0);
        add(1'b0,1'b1,1'b1,1'b1,32'h600,      1'b1,32'h1111_1111, 1'b1,32'h600,       32'h0,         32'h404,      1'b0,16'd0);
        add(1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,32'hA000_0600, 1'b1,32'h604,       32'hA000_0600, 32'h604,      1'b1,16'd0);
        add(1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,         1'b1,32'h604,       32'h0,         32'h604,      1'b0,16'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge Clk);
            #1;
            chk($sformatf("row%0d_req",   i), {31'd0, IMemReq},     {31'd0, vecs[i].e_req});
            chk($sformatf("row%0d_addr",  i), IMemAddr,             vecs[i].e_pc);
            chk($sformatf("row%0d_pc",    i), PC,                   vecs[i].e_pc);
            chk($sformatf("row%0d_instr", i), IF_IDInstruction,     vecs[i].e_instr);
            chk($sformatf("row%0d_pc4",   i), IF_IDPCPlus4,         vecs[i].e_pc4);
            chk($sformatf("row%0d_valid", i), {31'd0, IF_IDValid},  {31'd0, vecs[i].e_valid});
            chk($sformatf("row%0d_bub",   i), {16'd0, BubbleCount}, {16'd0, vecs[i].e_bub});
        end

        // Hand-written: address-tagged zero-wait stream from 0x604 for 8 cycles
        exp_pc = 32'h604;
        for (int k = 0; k < 8; k++) begin
            Reset = 1'b0; PCWrite = 1'b1; IF_IDWrite = 1'b1; BranchTaken = 1'b0;
            BranchTarget = 32'h0; IMemReady = 1'b1;
            IMemData = 32'hC000_0000 | exp_pc;
            @(posedge Clk);
            #1;
            chk($sformatf("stream%0d_instr", k), IF_IDInstruction, 32'hC000_0000 | exp_pc);
            exp_pc = exp_pc + 32'd4;
            chk($sformatf("stream%0d_pc4", k), IF_IDPCPlus4, exp_pc);
            chk($sformatf("stream%0d_pc", k), PC, exp_pc);
        end
        chk("stream_bub", {16'd0, BubbleCount}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_stage
